// File: rtl/soc_spi_sram_ctrl_if.sv
// Word-addressed shared memory port between the CPU top (master) and the SPI SRAM responder (slave).
interface soc_spi_sram_ctrl_if;
  logic [31:0] sram_addr;
  logic [31:0] sram_data_write;
  logic        sram_we;
  logic        sram_cs;
  logic [31:0] sram_data_read;
  logic        sram_ack;

  modport master (
    output sram_addr, sram_data_write, sram_we, sram_cs,
    input  sram_data_read, sram_ack
  );

  modport slave (
    input  sram_addr, sram_data_write, sram_we, sram_cs,
    output sram_data_read, sram_ack
  );
endinterface

// File: rtl/soc_spi_sram_ctrl.sv
// SPI SRAM responder: each request becomes one 64-bit mode-0 frame; sram_ack pulses 128 cycles after the request is taken.
// No backpressure: the initiator holds sram_cs until ack, and the next request is taken no sooner than 130 cycles later.
module soc_spi_sram_ctrl #(
  parameter logic [7:0] CMD_READ  = 8'h03,
  parameter logic [7:0] CMD_WRITE = 8'h02
) (
  input  logic                      clk,
  input  logic                      i_rst_n,
  soc_spi_sram_ctrl_if.slave        sram,
  output logic                      spi_cs_n,
  output logic                      spi_sck,
  output logic                      spi_mosi,
  input  logic                      spi_miso
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] rd_q, rd_d;
  logic [6:0]  bit_q, bit_d;
  logic        phase_q, phase_d;
  logic        we_q, we_d;
  logic        cs_n_q, cs_n_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic        ack_q, ack_d;

  logic [31:0] rx_shift;
  logic [31:0] wdata_bytes;
  logic [63:0] frame;
  logic        unused_addr_hi;

  // Upper word-address bits fall outside the 24-bit SRAM byte address.
  assign unused_addr_hi = &{1'b0, sram.sram_addr[31:22]};

  assign sram.sram_data_read = rd_q;
  assign sram.sram_ack       = ack_q;
  assign spi_cs_n            = cs_n_q;
  assign spi_sck             = sck_q;
  assign spi_mosi            = mosi_q;

  always_comb begin
    rx_shift    = {rx_q[30:0], spi_miso};
    wdata_bytes = {sram.sram_data_write[7:0],   sram.sram_data_write[15:8],
                   sram.sram_data_write[23:16], sram.sram_data_write[31:24]};
    frame       = {(sram.sram_we ? CMD_WRITE : CMD_READ),
                   sram.sram_addr[21:0], 2'b00,
                   (sram.sram_we ? wdata_bytes : 32'h0)};

    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rd_d    = rd_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    we_d    = we_q;
    cs_n_d  = cs_n_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    ack_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        sck_d  = 1'b0;
        mosi_d = 1'b0;
        if (sram.sram_cs) begin
          state_d = SHIFT;
          tx_d    = frame;
          we_d    = sram.sram_we;
          bit_d   = 7'd0;
          phase_d = 1'b0;
          cs_n_d  = 1'b0;
          mosi_d  = frame[63];
        end
      end
      SHIFT: begin
        if (!phase_q) begin
          sck_d   = 1'b1;
          phase_d = 1'b1;
        end else begin
          // End of phase H: SCK falls, next bit goes out, MISO is captured.
          sck_d   = 1'b0;
          phase_d = 1'b0;
          tx_d    = {tx_q[62:0], 1'b0};
          mosi_d  = tx_q[62];
          bit_d   = bit_q + 7'd1;
          if (bit_q >= 7'd32) begin
            rx_d = rx_shift;
          end
          if (bit_q == 7'd63) begin
            state_d = GAP;
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            ack_d   = 1'b1;
            if (!we_q) begin
              // First byte received lands in [7:0].
              rd_d = {rx_shift[7:0], rx_shift[15:8], rx_shift[23:16], rx_shift[31:24]};
            end
          end
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      rd_q    <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      we_q    <= 1'b0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rd_q    <= rd_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      we_q    <= we_d;
      cs_n_q  <= cs_n_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      ack_q   <= ack_d;
    end
  end

endmodule

// File: tb/tb_soc_spi_sram_ctrl.sv
// Bench for soc_spi_sram_ctrl: word-level memory reference plus a pin-level SPI SRAM device model.
`timescale 1ns/1ps
module tb_soc_spi_sram_ctrl;

  typedef struct {
    logic [63:0] frame;
    logic [31:0] rd;
    int          start;
  } exp_t;

  typedef struct {
    logic [127:0] name;
    logic [63:0]  act;
    logic [63:0]  exp;
  } chk_t;

  logic clk      = 1'b0;
  logic i_rst_n  = 1'b0;
  logic spi_cs_n;
  logic spi_sck;
  logic spi_mosi;
  logic spi_miso = 1'b0;

  soc_spi_sram_ctrl_if bus ();

  soc_spi_sram_ctrl #(.CMD_READ(8'h03), .CMD_WRITE(8'h02)) dut (
    .clk      (clk),
    .i_rst_n  (i_rst_n),
    .sram     (bus),
    .spi_cs_n (spi_cs_n),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t exp_q[$];
  chk_t chk_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  // Device power-up content: bytes 12..15 hold 78 56 34 12, elsewhere a fixed pattern.
  function automatic logic [7:0] dflt(input int a);
    logic [31:0] pat;
    pat = 32'h12345678;
    if (a >= 12 && a < 16) return pat[8*(a-12) +: 8];
    return a[7:0] ^ 8'h5A;
  endfunction

  // ---------------- SPI SRAM device model (pins) ----------------
  logic [7:0]  dev_mem [int];
  int          dev_bits = 0;
  int          dev_addr = 0;
  logic [7:0]  dev_cmd  = '0;
  logic [63:0] dev_frame = '0;
  logic [63:0] last_frame = '0;
  logic [31:0] dev_out = '0;

  function automatic logic [7:0] rd_byte(input int a);
    if (dev_mem.exists(a)) return dev_mem[a];
    return dflt(a);
  endfunction

  always @(negedge spi_cs_n or posedge spi_sck) begin
    if (!spi_sck) begin
      dev_bits  = 0;
      dev_frame = '0;
    end else begin
      dev_frame = {dev_frame[62:0], spi_mosi};
      dev_bits++;
      if (dev_bits == 8) dev_cmd = dev_frame[7:0];
      if (dev_bits == 32) begin
        dev_addr = int'(dev_frame[23:0]);
        dev_out  = {rd_byte(dev_addr), rd_byte(dev_addr + 1), rd_byte(dev_addr + 2), rd_byte(dev_addr + 3)};
      end
      if (dev_bits > 32 && dev_cmd == 8'h03) spi_miso = dev_out[64 - dev_bits];
      else                                   spi_miso = 1'($urandom);
      if (dev_bits == 64) begin
        last_frame = dev_frame;
        if (dev_cmd == 8'h02)
          for (int i = 0; i < 4; i++) dev_mem[dev_addr + i] = dev_frame[31 - 8*i -: 8];
      end
    end
  end

  int rst_sck = 0;
  always @(posedge spi_sck) if (!i_rst_n) rst_sck++;

  // ---------------- word-level reference ----------------
  logic [31:0] ref_mem [int];
  logic [31:0] model_rd = '0;

  function automatic logic [31:0] ref_read(input int wa);
    if (ref_mem.exists(wa)) return ref_mem[wa];
    return {dflt(4*wa + 3), dflt(4*wa + 2), dflt(4*wa + 1), dflt(4*wa)};
  endfunction

  function automatic logic [63:0] exp_frame(input logic we, input logic [31:0] addr, input logic [31:0] d);
    logic [63:0] f;
    int ba;
    ba = int'(addr[21:0]) * 4;
    f = '0;
    f[63:56] = we ? 8'h02 : 8'h03;
    f[55:32] = ba[23:0];
    if (we) for (int i = 0; i < 4; i++) f[31 - 8*i -: 8] = d[8*i +: 8];
    return f;
  endfunction

  task automatic post(input logic [127:0] name, input logic [63:0] act, input logic [63:0] exp);
    chk_t c;
    c.name = name; c.act = act; c.exp = exp;
    chk_q.push_back(c);
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] d,
                        input int start_off, input bit hold, input int drop_at);
    exp_t e;
    int   wa;
    bit   got;
    wa = int'(addr[21:0]);
    bus.sram_cs = 1'b1; bus.sram_we = we; bus.sram_addr = addr; bus.sram_data_write = d;
    e.frame = exp_frame(we, addr, d);
    e.start = cyc + start_off;
    if (we) ref_mem[wa] = d;
    else    model_rd = ref_read(wa);
    e.rd = model_rd;
    exp_q.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      if (i == drop_at) bus.sram_cs = 1'b0;
      if (bus.sram_ack) got = 1'b1;
    end
    post("ack_timeout", 64'(got), 64'd1);
    if (!hold) begin
      bus.sram_cs = 1'b0;
      bus.sram_data_write = $urandom;
    end
  endtask

  task automatic idle_gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit held;
    bit h;
    logic [31:0] a;
    int drop;
    bus.sram_cs = 1'b1; bus.sram_we = 1'b0;
    bus.sram_addr = 32'h0000_0100; bus.sram_data_write = 32'h0;
    idle_gap(5);
    post("rst_cs_n", 64'(spi_cs_n), 64'd1);
    post("rst_sck", 64'(spi_sck), 64'd0);
    post("rst_mosi", 64'(spi_mosi), 64'd0);
    post("rst_ack", 64'(bus.sram_ack), 64'd0);
    post("rst_rdata", 64'(bus.sram_data_read), 64'd0);
    post("rst_sck_edges", 64'(rst_sck), 64'd0);
    i_rst_n = 1'b1;
    do_req(1'b0, 32'h0000_0100, 32'h0, 1, 1'b0, -1);

    idle_gap(2);
    do_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1, 1'b0, -1);
    post("write_frame", last_frame, 64'h02000040_EFBEADDE);

    idle_gap(3);
    do_req(1'b0, 32'h0000_0003, 32'h0, 1, 1'b0, -1);
    post("read_frame", last_frame, 64'h0300000C_00000000);
    idle_gap(6);
    post("read_hold", 64'(bus.sram_data_read), 64'h12345678);

    do_req(1'b0, 32'hFFC0_0001, 32'h0, 1, 1'b0, -1);
    post("trunc_frame", last_frame, 64'h03000004_00000000);

    idle_gap(1);
    do_req(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1, 1'b1, -1);
    do_req(1'b0, 32'h0000_0020, 32'h0, 2, 1'b0, -1);

    idle_gap(2);
    do_req(1'b1, 32'h0000_0021, 32'h0BAD_1DEA, 1, 1'b0, 21);

    // Reset lands during bit 20 of a write; the write must not take effect.
    idle_gap(2);
    bus.sram_cs = 1'b1; bus.sram_we = 1'b1; bus.sram_addr = 32'h0000_0021; bus.sram_data_write = 32'h5555_AAAA;
    idle_gap(42);
    i_rst_n = 1'b0;
    #1;
    post("abort_cs_n", 64'(spi_cs_n), 64'd1);
    post("abort_sck", 64'(spi_sck), 64'd0);
    post("abort_ack", 64'(bus.sram_ack), 64'd0);
    post("abort_rdata", 64'(bus.sram_data_read), 64'd0);
    bus.sram_cs = 1'b0;
    model_rd = '0;
    idle_gap(3);
    i_rst_n = 1'b1;
    idle_gap(1);
    do_req(1'b0, 32'h0000_0021, 32'h0, 1, 1'b0, -1);

    held = 1'b0;
    for (int t = 0; t < 24; t++) begin
      if (!held) idle_gap($urandom_range(1, 4));
      a = ($urandom & 32'hFFC0_0000) | 32'($urandom_range(0, 7)) | ($urandom_range(0, 1) ? 32'h003F_FFF8 : 32'h0);
      h = (t != 23) && ($urandom_range(0, 3) == 0);
      drop = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 100)) : -1;
      do_req(1'($urandom), a, $urandom, held ? 2 : 1, h, drop);
      held = h;
    end
    idle_gap(4);
    done = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  logic        prev_cs_n = 1'b1;
  logic        prev_sck  = 1'b0;
  logic        ack_prev  = 1'b0;
  logic [31:0] hold_rd   = '0;
  int          mon_start = 0;
  int          mon_rises = 0;

  task automatic cmp(input logic [127:0] name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %0s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    chk_t c;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      cmp(c.name, c.act, c.exp);
    end
    if (!i_rst_n) begin
      prev_cs_n = 1'b1; prev_sck = 1'b0; ack_prev = 1'b0; hold_rd = '0;
    end else begin
      if (ack_prev) cmp("ack_width", 64'(bus.sram_ack), 64'd0);
      if (prev_cs_n && !spi_cs_n) begin
        mon_start = cyc;
        mon_rises = 0;
        cmp("rdata_held", 64'(bus.sram_data_read), 64'(hold_rd));
      end
      if (!prev_sck && spi_sck) mon_rises++;
      if (bus.sram_ack && !ack_prev) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_ack: got ack, expected none (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          cmp("start_cycle", 64'(mon_start), 64'(e.start));
          cmp("ack_latency", 64'(cyc - mon_start), 64'd128);
          cmp("sck_rises", 64'(mon_rises), 64'd64);
          cmp("mosi_frame", last_frame, e.frame);
          cmp("cs_n_at_ack", 64'(spi_cs_n), 64'd1);
          cmp("rdata", 64'(bus.sram_data_read), 64'(e.rd));
          hold_rd = e.rd;
        end
      end
      ack_prev = bus.sram_ack; prev_cs_n = spi_cs_n; prev_sck = spi_sck;
    end
    if (done || cyc > 60000) begin
      if (!done) begin
        n_vec++; n_bad++;
        $display("FAIL watchdog: stimulus unfinished at cycle %0d, expected done", cyc);
      end
      cmp("pending_expect", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
    end
  end

endmodule

// File: doc/soc_spi_sram_ctrl.md
# soc_spi_sram_ctrl

SRAM-side responder for the SoC's shared word-addressed memory port: it accepts the `sram_cs`/`sram_we`/`sram_ack` requests issued by the CPU top and serves each one from an external serial SPI SRAM (23LC1024-class, 24-bit addressing, SPI mode 0). Each request becomes exactly one 64-bit SPI frame: command, address, then 4 data bytes. `sram_ack` pulses once when the frame completes. The block sits between the CPU top's memory port and the chip pins.

## Interface
- `CMD_READ`, default 8'h03, SPI read opcode.
- `CMD_WRITE`, default 8'h02, SPI write opcode.

- `clk`  in  1  system clock; `spi_sck` runs at clk/2.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `sram_addr`  in  32  word address; bits [21:0] used, [31:22] ignored.
- `sram_data_write`  in  32  write data.
- `sram_we`  in  1  1 = write, 0 = read; sampled at request start only.
- `sram_cs`  in  1  request valid, level; initiator holds it until ack.
- `sram_data_read`  out  32  registered read data.
- `sram_ack`  out  1  one-cycle completion pulse.
- `spi_cs_n`  out  1  SPI chip select, active low.
- `spi_sck`  out  1  SPI clock, idle low.
- `spi_mosi`  out  1  serial data out.
- `spi_miso`  in  1  serial data in.

## Operation
- FSM states:
  - IDLE: on `sram_cs`=1, go to SHIFT. Latch the 64-bit TX shift register {opcode, byte address {sram_addr[21:0],2'b00}, data bytes}. Latch `sram_we`. Clear the 7-bit bit counter and the phase bit.
  - SHIFT: 64 bits, 2 cycles per bit (phase L then phase H). After bit 63 phase H, go to GAP.
  - GAP: one cycle, then IDLE.
- Opcode: `CMD_WRITE` if we=1, else `CMD_READ`.
- Data byte order is little-endian: [7:0] is sent first, then [15:8], [23:16], [31:24]. Every byte and the 24-bit address are sent MSB first.
- For reads, the TX data field is all zeros.
- MOSI: `spi_mosi` = TX shift register MSB. The register shifts left at the edge ending each phase H.
- MISO: sampled at the edge ending each phase H, for bits 32..63 only. Bytes are reassembled into the RX register with the same byte order (first received byte → [7:0]).
- `sram_data_read` updates only at completion of a read. It holds its value across writes and idle.
- `sram_cs` is not monitored during SHIFT/GAP. If it drops mid-frame, the frame still completes and the ack is still issued.
- Address bits [31:22] have no effect.
- Outputs in IDLE/GAP: `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0.

## Timing
- All outputs are registered.
- Reset values: `sram_ack`=0, `sram_data_read`=0, `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0, FSM=IDLE.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronous). No ack is issued. The aborted frame is not resumed.
- Let edge n be the edge at which IDLE samples `sram_cs`=1.
  - Edge n: `spi_cs_n`←0, `spi_mosi`←opcode bit 7.
  - Bit k (k = 0..63): `spi_sck` rises at edge n+2k+1 and falls at edge n+2k+2. MISO is sampled at edge n+2k+2.
  - Edge n+128: `spi_cs_n`←1, `spi_sck`=0, `sram_ack`←1, and for reads `sram_data_read`←assembled word.
  - Edge n+129: `sram_ack`←0, FSM in GAP.
  - Edge n+130: FSM back in IDLE; a new request can be sampled no earlier than this edge.
- Request-to-ack latency is 128 cycles. Minimum spacing between request starts is 130 cycles.
- `spi_cs_n` stays high for at least 2 cycles between frames.
- The one-cycle GAP ensures a `sram_cs` that is still high in the cycle after ack is not taken as a new request.

## Test plan
- Reset: hold `i_rst_n`=0 with `sram_cs`=1 → all outputs at reset values, no SCK toggles. Release → frame starts on the first edge.
- Write: addr 0x00000010, data 0xDEADBEEF, we=1 → MOSI bytes 02 00 00 40 EF BE AD DE. Exactly 64 SCK rising edges. `sram_ack` high for exactly one cycle, 128 cycles after request sample. `sram_data_read` unchanged.
- Read: addr 0x00000003, SPI model returns bytes 78 56 34 12 → MOSI 03 00 00 0C followed by 32 zero bits. At ack, `sram_data_read`=0x12345678, and it holds after ack.
- Address truncation: addr 0xFFC00001 → transmitted address 0x000004.
- Back-to-back: `sram_cs` held high across ack → second frame's `spi_cs_n` falls exactly 130 cycles after the first frame's start, with 2 cycles of `spi_cs_n` high between frames. Exactly one ack per frame.
- Abort and glitch:
  - Assert reset during bit 20 → `spi_cs_n`=1 immediately and no ack; a following read completes correctly.
  - Drop `sram_cs` at bit 10 → frame still completes and acks.
